// File: rtl/uart_tx_framer_if.sv
// Byte handshake between a producer and the UART transmit framer.
// The producer drives data/valid; the framer answers with ready.
interface uart_tx_framer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// A one-entry holding register lets the next byte queue behind the current frame.
module uart_tx_framer #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_framer_if.slave  tx_if,
    output logic             uart_tx,
    output logic             tx_busy
);
    localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic           ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tx_ready_int;
    logic                 accept;
    logic                 bit_end;
    logic                 load;

    assign tx_ready_int   = !hold_full_q && !reset;
    assign tx_if.tx_ready = tx_ready_int;
    assign accept         = tx_if.tx_valid && tx_ready_int;
    assign bit_end        = (baud_q == BAUD_LAST);
    assign uart_tx        = tx_q;
    assign tx_busy        = busy_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        load     = 1'b0;

        // tx_d is the line level for the next cycle, so every bit boundary
        // sets up the following bit one cycle ahead of the register.
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (hold_full_q) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d  = START;
            baud_d   = '0;
            bit_d    = 3'd0;
            shift_d  = hold_q;
            parity_d = (^hold_q) ^ ODD_BIT;
            tx_d     = 1'b0;
        end

        // A new accept wins over the load freeing the slot on the same edge.
        hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
        hold_d      = accept ? tx_if.tx_data : hold_q;
        busy_d      = (state_d != IDLE) || hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three instances (8N1, 8E2, 8O2) at CLK_DIV=4, with a
// per-cycle line log checked against frame-level expectations and a log decoder.
module tb_uart_tx_framer;
    localparam int CD   = 4;
    localparam int NDUT = 3;
    localparam int LOGN = 8192;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       reset;
    int         cyc;
    int         n_checks;
    int         n_fails;
    logic [7:0] drv_data [NDUT];
    logic       drv_valid[NDUT];
    logic       rdy_w [NDUT];
    logic       line_w[NDUT];
    logic       busy_w[NDUT];
    logic       line_log[NDUT][LOGN];
    logic       busy_log[NDUT][LOGN];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            uart_tx_framer_if #(.DATA_BITS(8)) bus ();
            assign bus.tx_data  = drv_data[gi];
            assign bus.tx_valid = drv_valid[gi];
            assign rdy_w[gi]    = bus.tx_ready;
            uart_tx_framer #(
                .CLK_DIV   (CD),
                .DATA_BITS (8),
                .PARITY_EN ((gi > 0) ? 1 : 0),
                .PARITY_ODD((gi == 2) ? 1 : 0),
                .STOP_BITS ((gi > 0) ? 2 : 1)
            ) dut (
                .clk    (clk),
                .reset  (reset),
                .tx_if  (bus),
                .uart_tx(line_w[gi]),
                .tx_busy(busy_w[gi])
            );
        end
    endgenerate

    // log[c] holds the value present between edge c and edge c+1
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            line_log[i][cyc % LOGN] <= line_w[i];
            busy_log[i][cyc % LOGN] <= busy_w[i];
        end
    end

    function automatic int cfg_pe(input int g); return (g > 0) ? 1 : 0; endfunction
    function automatic logic cfg_po(input int g); return (g == 2); endfunction
    function automatic int cfg_sb(input int g); return (g > 0) ? 2 : 1; endfunction
    function automatic int frame_len(input int g); return (1 + 8 + cfg_pe(g) + cfg_sb(g)) * CD; endfunction

    // Expected line level k cycles into a frame carrying byte b
    function automatic logic model_level(input int g, input logic [7:0] b, input int k);
        int i;
        i = k / CD;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (cfg_pe(g) != 0 && i == 9) return (^b) ^ cfg_po(g);
        return 1'b1;
    endfunction

    function automatic logic lg(input int g, input int c); return line_log[g][c % LOGN]; endfunction
    function automatic logic bg(input int g, input int c); return busy_log[g][c % LOGN]; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send(input int g, input logic [7:0] b, output int acc);
        logic r;
        drv_data[g]  = b;
        drv_valid[g] = 1'b1;
        acc = -1;
        for (int t = 0; t < 400; t++) begin
            r = rdy_w[g];
            tick();
            if (r) begin
                acc = cyc;
                break;
            end
        end
        chk($sformatf("accept_g%0d_%02h", g, b), (acc >= 0), 1);
    endtask

    task automatic check_wave(input int g, input int start, input byte_q_t bq);
        int pos;
        pos = start;
        chk($sformatf("idle_before_g%0d", g), lg(g, start - 1), 1'b1);
        foreach (bq[j]) begin
            for (int k = 0; k < frame_len(g); k++)
                chk($sformatf("wave_g%0d_f%0d_k%0d", g, j, k), lg(g, pos + k), model_level(g, bq[j], k));
            pos += frame_len(g);
        end
    endtask

    function automatic int first_low(input int g, input int from, input int to);
        for (int i = from; i < to; i++) if (lg(g, i) == 1'b0) return i;
        return -1;
    endfunction

    function automatic int busy_fall(input int g, input int from, input int to);
        for (int i = from; i < to; i++) if (bg(g, i) == 1'b0) return i;
        return -1;
    endfunction

    task automatic decode(input int g, input int from, input int to, output byte_q_t got);
        int         i;
        logic [7:0] b;
        got = {};
        i = from;
        while (i + frame_len(g) <= to) begin
            if (lg(g, i) == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = lg(g, i + (1 + k) * CD + CD / 2);
                if (cfg_pe(g) != 0)
                    chk($sformatf("rx_parity_g%0d", g), lg(g, i + 9 * CD + CD / 2), (^b) ^ cfg_po(g));
                for (int s = 0; s < cfg_sb(g); s++)
                    chk($sformatf("rx_stop_g%0d", g), lg(g, i + (9 + cfg_pe(g) + s) * CD + CD / 2), 1'b1);
                got.push_back(b);
                i += frame_len(g);
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        int      a, a2, a3, st, fl, bf, cnt, e, from;
        byte_q_t bq, exp_q, got;
        logic [7:0] rb;

        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            drv_data[i]  = 8'h00;
            drv_valid[i] = 1'b0;
        end

        // Reset held for three edges
        for (int r = 0; r < 3; r++) begin
            tick();
            for (int g = 0; g < NDUT; g++) begin
                chk($sformatf("rst_line_g%0d", g), line_w[g], 1'b1);
                chk($sformatf("rst_busy_g%0d", g), busy_w[g], 1'b0);
                chk($sformatf("rst_ready_g%0d", g), rdy_w[g], 1'b0);
            end
        end
        reset = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) chk($sformatf("ready_after_rst_g%0d", g), rdy_w[g], 1'b1);
        tick();
        tick();

        // Single 8N1 frame of 0xA5
        send(0, 8'hA5, a);
        drv_valid[0] = 1'b0;
        chk("busy_on_accept", busy_w[0], 1'b1);
        wait_cyc(a + 1 + frame_len(0) + 4);
        fl = first_low(0, a, a + 60);
        chk("start_edge", fl, a + 1);
        bf = busy_fall(0, a, a + 100);
        chk("frame_len_8n1", bf - fl, 40);
        bq = {8'hA5};
        check_wave(0, a + 1, bq);

        // Back-to-back 0x00 then 0xFF with valid held
        send(0, 8'h00, a);
        send(0, 8'hFF, a2);
        drv_valid[0] = 1'b0;
        chk("ready_reassert", a2 - a, 2);
        wait_cyc(a + 1 + 2 * frame_len(0) + 4);
        bq = {8'h00, 8'hFF};
        check_wave(0, a + 1, bq);
        cnt = 0;
        for (int i = a; i < a + 81; i++) if (bg(0, i)) cnt++;
        // one cycle in the holding register plus two 40-cycle frames
        chk("b2b_busy_cycles", cnt, 81);
        chk("b2b_busy_fall", bg(0, a + 81), 1'b0);
        chk("b2b_busy_before", bg(0, a - 1), 1'b0);

        // Parity even / odd with two stop bits
        for (int g = 1; g < NDUT; g++) begin
            send(g, 8'h07, a);
            drv_valid[g] = 1'b0;
            wait_cyc(a + 1 + frame_len(g) + 4);
            st = a + 1;
            chk($sformatf("parity_bit_g%0d", g), lg(g, st + 9 * CD + CD / 2), (g == 1) ? 1'b1 : 1'b0);
            cnt = 0;
            for (int i = st + 10 * CD; i < st + 12 * CD; i++) if (lg(g, i)) cnt++;
            chk($sformatf("stop_high_g%0d", g), cnt, 8);
            chk($sformatf("frame_len_g%0d", g), busy_fall(g, a, a + 100) - st, 48);
            bq = {8'h07};
            check_wave(g, st, bq);
        end

        // Backpressure: third byte waits for the holding register to drain
        send(0, 8'h11, a);
        send(0, 8'h22, a2);
        chk("hold_full_ready", rdy_w[0], 1'b0);
        send(0, 8'h33, a3);
        drv_valid[0] = 1'b0;
        chk("bp_accept2", a2, a + 2);
        chk("bp_accept3", a3, a + 2 + frame_len(0));
        wait_cyc(a + 1 + 3 * frame_len(0) + 4);
        bq = {8'h11, 8'h22, 8'h33};
        check_wave(0, a + 1, bq);

        // Randomized traffic checked by decoding the line log
        for (int g = 0; g < NDUT; g++) begin
            exp_q = {};
            from = cyc;
            for (int n = 0; n < 12; n++) begin
                if ($urandom_range(0, 1) != 0) begin
                    cnt = $urandom_range(0, 60);
                    for (int t = 0; t < cnt; t++) tick();
                end
                rb = 8'($urandom);
                send(g, rb, a);
                drv_valid[g] = 1'b0;
                exp_q.push_back(rb);
            end
            for (int t = 0; t < 2000 && busy_w[g]; t++) tick();
            chk($sformatf("rand_drain_g%0d", g), busy_w[g], 1'b0);
            tick();
            tick();
            decode(g, from, cyc, got);
            chk($sformatf("rand_count_g%0d", g), got.size(), exp_q.size());
            foreach (exp_q[j])
                if (j < got.size()) chk($sformatf("rand_byte_g%0d_%0d", g, j), got[j], exp_q[j]);
        end

        // Reset during data bit 3 with a byte held
        send(0, 8'h5A, a);
        send(0, 8'hC3, a2);
        drv_valid[0] = 1'b0;
        wait_cyc(a + 1 + 4 * CD + 1);
        chk("pre_rst_bit3", line_w[0], model_level(0, 8'h5A, cyc - (a + 1)));
        reset = 1'b1;
        tick();
        chk("mid_rst_line", line_w[0], 1'b1);
        chk("mid_rst_busy", busy_w[0], 1'b0);
        chk("mid_rst_ready", rdy_w[0], 1'b0);
        reset = 1'b0;
        e = cyc;
        wait_cyc(e + 150);
        cnt = 0;
        for (int i = e; i < e + 140; i++) if (lg(0, i) == 1'b0 || bg(0, i) == 1'b1) cnt++;
        chk("no_resume_after_rst", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
